// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - condition codes and state encoding shared with core control
package mc_pkg;

   localparam logic [3:0] COND_IDLE  = 4'b0000;
   localparam logic [3:0] COND_TRANS = 4'b1100;
   localparam logic [3:0] COND_PROC  = 4'b1111;
   localparam logic [3:0] COND_DONE  = 4'b1110;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_STORE   = 3'd1,
      ST_FETCH   = 3'd2,
      ST_STAGED  = 3'd3,
      ST_RUN     = 3'd4,
      ST_DRAINED = 3'd5
   } mc_state_t;

endpackage

// File: rtl/mc_data_ram.sv
// rtl/mc_data_ram.sv - single-port synchronous-read RAM, write-first
module mc_data_ram #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 64
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
         o_rdata       <= i_wdata;
      end else begin
         o_rdata       <= r_mem[i_addr];
      end
   end

endmodule

// File: rtl/mc_operand_server.sv
// rtl/mc_operand_server.sv - stores a DMA batch, then serves it back as operand pairs
module mc_operand_server
   import mc_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 64
) (
   input  logic              ctrl_clk,
   input  logic              ctrl_reset,
   input  logic              mc_we,
   input  logic [ADDR_W-1:0] mc_data_address_in,
   input  logic [3:0]        ctrl_data_contition,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_in_valid,
   output logic [DATA_W-1:0] procc_opa,
   output logic [DATA_W-1:0] procc_opb,
   output logic              mc_cont_procc,
   output logic              mc_data_done,
   output logic              mc_err,
   output logic [ADDR_W:0]   mc_word_count
);

   mc_state_t         r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_base, r_rd_ptr, r_pairs_left;
   logic [ADDR_W:0]   r_wr_ptr, r_count;
   logic              r_fetch_busy;
   logic [1:0]        r_phase;
   logic [DATA_W-1:0] r_stage_a, r_stage_b, r_opa, r_opb;
   logic              r_stage_valid, r_err, r_done;

   logic              w_restart, w_store_wr, w_store_ovf, w_store_exit;
   logic              w_issue, w_run_done, w_fetch_start, w_underrun, w_last_odd;
   logic              w_ram_we;
   logic [ADDR_W-1:0] w_ram_addr, w_rd_addr;
   logic [DATA_W-1:0] w_ram_rdata;
   logic [ADDR_W+1:0] w_count_p1;

   always_comb begin
      w_state_nxt  = r_state;
      w_restart    = 1'b0;
      w_store_wr   = 1'b0;
      w_store_ovf  = 1'b0;
      w_store_exit = 1'b0;
      w_issue      = 1'b0;
      w_run_done   = 1'b0;
      case (r_state)
         ST_IDLE, ST_DRAINED: begin
            if (mc_we) begin
               w_restart   = 1'b1;
               w_state_nxt = ST_STORE;
            end
         end
         ST_STORE: begin
            if (mc_we) begin
               // wr_ptr bit ADDR_W set means the top word is already written; no wrap
               if (data_in_valid && !r_wr_ptr[ADDR_W]) w_store_wr  = 1'b1;
               if (data_in_valid &&  r_wr_ptr[ADDR_W]) w_store_ovf = 1'b1;
            end else if (ctrl_data_contition == COND_TRANS) begin
               w_store_exit = 1'b1;
               w_state_nxt  = (r_count == '0) ? ST_DRAINED : ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (r_phase == 2'd2) w_state_nxt = ST_STAGED;
         end
         ST_STAGED: begin
            if (ctrl_data_contition == COND_PROC) begin
               w_issue     = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (ctrl_data_contition == COND_DONE) begin
               w_run_done  = 1'b1;
               w_state_nxt = r_stage_valid ? ST_STAGED : ST_DRAINED;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
      if (ctrl_reset) r_state <= ST_IDLE;
      else            r_state <= w_state_nxt;
   end

   assign w_fetch_start = (w_store_exit && (r_count != '0)) ||
                          (w_issue && (r_pairs_left != '0));
   assign w_underrun    = w_run_done && !r_stage_valid && (r_pairs_left != '0);
   assign w_last_odd    = (r_pairs_left == ADDR_W'(1)) && r_count[0];
   assign w_count_p1    = {1'b0, r_count} + (ADDR_W+2)'(1);

   assign w_ram_we   = (w_restart && data_in_valid) || w_store_wr;
   assign w_rd_addr  = (r_phase == 2'd1) ? r_rd_ptr + ADDR_W'(1) : r_rd_ptr;
   assign w_ram_addr = w_restart  ? mc_data_address_in :
                       w_store_wr ? r_wr_ptr[ADDR_W-1:0] : w_rd_addr;

   mc_data_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .i_clk   (ctrl_clk),
      .i_we    (w_ram_we),
      .i_addr  (w_ram_addr),
      .i_wdata (data_in),
      .o_rdata (w_ram_rdata)
   );

   always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         r_base        <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_pairs_left  <= '0;
         r_fetch_busy  <= 1'b0;
         r_phase       <= 2'd0;
         r_stage_a     <= '0;
         r_stage_b     <= '0;
         r_stage_valid <= 1'b0;
         r_opa         <= '0;
         r_opb         <= '0;
         r_err         <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         if (w_restart) begin
            r_base   <= mc_data_address_in;
            r_wr_ptr <= {1'b0, mc_data_address_in} + {{ADDR_W{1'b0}}, data_in_valid};
            r_count  <= {{ADDR_W{1'b0}}, data_in_valid};
            r_err    <= 1'b0;
            r_done   <= 1'b0;
         end
         if (w_store_wr) begin
            r_wr_ptr <= r_wr_ptr + (ADDR_W+1)'(1);
            if (r_count != (ADDR_W+1)'(DEPTH)) r_count <= r_count + (ADDR_W+1)'(1);
         end
         if (w_store_ovf) r_err <= 1'b1;
         if (w_store_exit) begin
            r_rd_ptr     <= r_base;
            r_pairs_left <= w_count_p1[ADDR_W:1];
            if (r_count == '0) r_done <= 1'b1;
         end

         // three-phase fetch: address, capture A / address+1, capture B
         if (w_fetch_start) begin
            r_fetch_busy <= 1'b1;
            r_phase      <= 2'd0;
         end else if (r_fetch_busy) begin
            case (r_phase)
               2'd0: r_phase <= 2'd1;
               2'd1: begin
                  r_stage_a <= w_ram_rdata;
                  r_phase   <= 2'd2;
               end
               default: begin
                  r_stage_b     <= w_last_odd ? '0 : w_ram_rdata;
                  r_stage_valid <= 1'b1;
                  r_rd_ptr      <= r_rd_ptr + ADDR_W'(2);
                  r_pairs_left  <= r_pairs_left - ADDR_W'(1);
                  r_fetch_busy  <= 1'b0;
                  r_phase       <= 2'd0;
               end
            endcase
         end

         if (w_issue) begin
            r_opa         <= r_stage_a;
            r_opb         <= r_stage_b;
            r_stage_valid <= 1'b0;
         end
         if (w_run_done && !r_stage_valid) begin
            r_done       <= 1'b1;
            r_fetch_busy <= 1'b0;
            r_phase      <= 2'd0;
            if (w_underrun) r_err <= 1'b1;
         end
      end
   end

   assign procc_opa     = r_opa;
   assign procc_opb     = r_opb;
   assign mc_cont_procc = r_stage_valid;
   assign mc_data_done  = r_done;
   assign mc_err        = r_err;
   assign mc_word_count = r_count;

endmodule
